my_mul16: RTL

Sequential 16x16 unsigned shift-and-add multiplier built around the existing 16-bit ripple adder (`my_add16`), which is its only arithmetic resource. It consumes the adder's sum once per cycle to accumulate partial products. It returns the low 16 bits of the product plus an overflow flag. It serves as the multi-cycle multiply unit beside the ALU, with a start/done handshake.

---
 rtl/my_mul16.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/my_mul16.sv
// -----------------------------------------------------------------------------
// my_mul16 : sequential 16x16 unsigned shift-and-add multiplier.
//
// The only arithmetic resource is the 16-bit ripple adder my_add16 (defined
// below). One partial product is accumulated per RUN cycle. The result is the
// low 16 bits of the product plus an exact overflow flag (a*b >= 2^16).
//
// Ports (my_mul16):
//   clk_i     in   1   rising-edge clock
//   rst_n_i   in   1   synchronous, active-low reset
//   start_i   in   1   request, sampled only in IDLE
//   a_i       in  16   multiplicand, captured when start is accepted
//   b_i       in  16   multiplier, captured when start is accepted
//   busy_o    out  1   high whenever the FSM is not IDLE
//   done_o    out  1   one-cycle pulse, out_o/ovf_o valid in that cycle
//   out_o     out 16   product modulo 2^16, held until the next done
//   ovf_o     out  1   full product >= 2^16, held with out_o
//
// Build option:
//   MY_MUL16_EARLY_EXIT_EN  when defined, RUN ends as soon as no multiplier
//                           bits remain (latency depends on b); otherwise
//                           RUN always takes 16 cycles. Results are identical.
// -----------------------------------------------------------------------------

// 16-bit ripple-carry adder. The carry-out is intentionally not exported; the
// multiplier reconstructs it from the operand and sum MSBs.
module my_add16 (
    input  logic [15:0] a_i,
    input  logic [15:0] b_i,
    output logic [15:0] sum_o
);

    logic carry;

    always_comb begin
        sum_o = '0;
        carry = 1'b0;
        for (int i = 0; i < 16; i++) begin
            sum_o[i] = a_i[i] ^ b_i[i] ^ carry;
            carry    = (a_i[i] & b_i[i]) | (carry & (a_i[i] ^ b_i[i]));
        end
    end

endmodule

// State table
//   state  | meaning
//   IDLE   | waiting for start_i; operands captured on acceptance
//   RUN    | one shift-and-add iteration per cycle
//   DONE   | done_o pulse; out_o/ovf_o valid; start_i ignored
module my_mul16 #(
    parameter int WIDTH = 16
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             start_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] out_o,
    output logic             ovf_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [3:0]       cnt_q, cnt_d;
    logic             lost_q, lost_d;
    logic             cflag_q, cflag_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic             ovf_q, ovf_d;

    logic [WIDTH-1:0] sum;
    logic             add_carry;
    logic             last_iter;

    my_add16 u_add (
        .a_i   (acc_q),
        .b_i   (mcand_q),
        .sum_o (sum)
    );

    // Carry-out of acc+mcand recovered from the MSBs: both set always carries;
    // exactly one set carries when the sum MSB came out clear.
    assign add_carry = (acc_q[WIDTH-1] & mcand_q[WIDTH-1])
                     | ((acc_q[WIDTH-1] ^ mcand_q[WIDTH-1]) & ~sum[WIDTH-1]);

`ifdef MY_MUL16_EARLY_EXIT_EN
    // Once the shifted multiplier is empty no further adds can occur, so the
    // accumulator and carry flag are already final.
    assign last_iter = (cnt_q == 4'd15) || (mplier_q[WIDTH-1:1] == '0);
`else
    assign last_iter = (cnt_q == 4'd15);
`endif

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q  <= S_IDLE;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            lost_q   <= 1'b0;
            cflag_q  <= 1'b0;
            out_q    <= '0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            lost_q   <= lost_d;
            cflag_q  <= cflag_d;
            out_q    <= out_d;
            ovf_q    <= ovf_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        lost_d   = lost_q;
        cflag_d  = cflag_q;
        out_d    = out_q;
        ovf_d    = ovf_q;

        unique case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d  = S_RUN;
                    mcand_d  = a_i;
                    mplier_d = b_i;
                    acc_d    = '0;
                    cnt_d    = '0;
                    lost_d   = 1'b0;
                    cflag_d  = 1'b0;
                end
            end

            S_RUN: begin
                if (mplier_q[0]) begin
                    acc_d = sum;
                    // A multiplicand bit already shifted out means this
                    // partial product alone reaches 2^16.
                    cflag_d = cflag_q | add_carry | lost_q;
                end
                lost_d   = lost_q | mcand_q[WIDTH-1];
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + 4'd1;
                if (last_iter) begin
                    state_d = S_DONE;
                    // Capture includes this cycle's partial product.
                    out_d   = acc_d;
                    ovf_d   = cflag_d;
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign busy_o = (state_q != S_IDLE);
    assign done_o = (state_q == S_DONE);
    assign out_o  = out_q;
    assign ovf_o  = ovf_q;

endmodule
